// File: rtl/wam_pkg.sv
// wam_pkg: constants shared by the whack-a-mole light controller and hit detector.
//   - FSM state encodings for hit_detector (3-bit)
//   - mole count and the timing / position / flick-count widths
package wam_pkg;

    localparam int NUM_MOLES = 9;
    localparam int TIME_W    = 28;
    localparam int POS_W     = 4;
    localparam int FLICK_W   = 6;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_LIGHT = 3'd1;
    localparam logic [2:0] S_ARMED      = 3'd2;
    localparam logic [2:0] S_RESOLVED   = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = S_IDLE,
        ST_WAIT_LIGHT = S_WAIT_LIGHT,
        ST_ARMED      = S_ARMED,
        ST_RESOLVED   = S_RESOLVED,
        ST_DONE       = S_DONE
    } state_e;

endpackage

// File: rtl/hit_detector_if.sv
// hit_detector_if: game-side bundle between the light controller / score display
// and the hit detector.
//   master: drives start, lights, light_pos, light_counter; receives the tallies
//   slave : the hit detector
//   start, lights[8:0], light_pos[3:0], light_counter[5:0] -> detector
//   score, misses [SCORE_W-1:0], hit_pulse, miss_pulse, game_over -> display
interface hit_detector_if #(
    parameter int SCORE_W = 8
);
    import wam_pkg::*;

    logic                 start;
    logic [NUM_MOLES-1:0] lights;
    logic [POS_W-1:0]     light_pos;
    logic [FLICK_W-1:0]   light_counter;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   misses;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 game_over;

    modport master (
        output start, lights, light_pos, light_counter,
        input  score, misses, hit_pulse, miss_pulse, game_over
    );

    modport slave (
        input  start, lights, light_pos, light_counter,
        output score, misses, hit_pulse, miss_pulse, game_over
    );

endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: turns the nine raw asynchronous mole buttons into
// single-cycle press strobes.
//   clk, reset (sync, active-high)
//   buttons[8:0] : raw active-high buttons
//   press[8:0]   : one-cycle strobe on each 0->1 of the conditioned level
// Optional macro WAM_DEBOUNCE_EN: the synchronized level must hold for
// DEBOUNCE_CYCLES consecutive cycles before the conditioned level follows it.
module button_conditioner
    import wam_pkg::*;
#(
    parameter logic [TIME_W-1:0] DEBOUNCE_CYCLES = 28'd500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_MOLES-1:0] buttons,
    output logic [NUM_MOLES-1:0] press
);

    logic [NUM_MOLES-1:0] sync1_q, sync1_d;
    logic [NUM_MOLES-1:0] sync2_q, sync2_d;
    logic [NUM_MOLES-1:0] prev_q, prev_d;
    logic [NUM_MOLES-1:0] level;

    always_comb begin
        sync1_d = buttons;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef WAM_DEBOUNCE_EN
    // Down-counter per button, reloaded whenever the synchronized input agrees
    // with the accepted level; the level flips when a disagreement reaches
    // terminal count, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
    localparam logic [TIME_W-1:0] RELOAD = DEBOUNCE_CYCLES - TIME_W'(1);

    logic [TIME_W-1:0]    cnt_q [NUM_MOLES];
    logic [TIME_W-1:0]    cnt_d [NUM_MOLES];
    logic [NUM_MOLES-1:0] stable_q, stable_d;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_MOLES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = RELOAD;
            end else if (cnt_q[i] == '0) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = RELOAD;
            end else begin
                cnt_d[i] = cnt_q[i] - TIME_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_MOLES; i++) cnt_q[i] <= RELOAD;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NUM_MOLES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level = stable_q;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign level = sync2_q;
`endif

    assign press = level & ~prev_q;

endmodule

// File: rtl/hit_detector.sv
// hit_detector: matches mole button presses against the lit position and keeps
// per-game hit / miss tallies.
//   clk, reset (sync, active-high)
//   buttons[8:0] : raw mole buttons (active-high, asynchronous)
//   bus          : hit_detector_if.slave (game inputs in, tallies/strobes out)
// Optional macro WAM_DEBOUNCE_EN enables per-button debounce in the conditioner.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no game; counters hold; start=1 clears them and begins
// WAIT_LIGHT | between flicks; any press is a false whack
// ARMED      | a mole is lit; first press decides hit or miss
// RESOLVED   | flick already scored; presses ignored until light goes off
// DONE       | game over; counters frozen until start drops
module hit_detector
    import wam_pkg::*;
#(
    parameter int unsigned       ROUNDS          = 30,
    parameter int                SCORE_W         = 8,
    parameter logic [TIME_W-1:0] DEBOUNCE_CYCLES = 28'd500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_MOLES-1:0] buttons,
    hit_detector_if.slave        bus
);

    localparam logic [FLICK_W-1:0] ROUNDS_L  = FLICK_W'(ROUNDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [NUM_MOLES-1:0] press;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .press   (press)
    );

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] misses_q, misses_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               miss_pulse_q, miss_pulse_d;

    logic   any_press;
    logic   hit_press;
    logic   lit;
    state_e round_end;

    always_comb begin
        any_press = |press;
        lit       = |bus.lights;
        // Out-of-range positions never match, so every press becomes a miss.
        hit_press = (bus.light_pos <= POS_W'(NUM_MOLES - 1)) && press[bus.light_pos];
        round_end = (bus.light_counter >= ROUNDS_L) ? ST_DONE : ST_WAIT_LIGHT;
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    score_d  = '0;
                    misses_d = '0;
                    state_d  = ST_WAIT_LIGHT;
                end
            end
            ST_WAIT_LIGHT: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end else begin
                    // A press landing in the same cycle the light appears is
                    // still a false whack; the light only arms next cycle.
                    if (any_press) miss_pulse_d = 1'b1;
                    if (lit) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end else if (hit_press) begin
                    hit_pulse_d = 1'b1;
                    state_d     = ST_RESOLVED;
                end else if (any_press) begin
                    miss_pulse_d = 1'b1;
                    state_d      = ST_RESOLVED;
                end else if (!lit) begin
                    miss_pulse_d = 1'b1;
                    state_d      = round_end;
                end
            end
            ST_RESOLVED: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end else if (!lit) begin
                    state_d = round_end;
                end
            end
            ST_DONE: begin
                if (!bus.start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (hit_pulse_d && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
        if (miss_pulse_d && (misses_q != SCORE_MAX)) misses_d = misses_q + SCORE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            misses_q     <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.game_over  = (state_q == ST_DONE);

endmodule

// File: tb/tb_hit_detector.sv
// tb_hit_detector: directed bench for hit_detector. A second instance with a
// 2-bit score follows the same stimulus to exercise counter saturation.
module tb_hit_detector;
    import wam_pkg::*;

`ifdef WAM_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int LAT  = 3 + DB;
    localparam int HOLD = 1 + DB;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] buttons;

    always #5 clk = ~clk;

    hit_detector_if #(.SCORE_W(8)) bus   ();
    hit_detector_if #(.SCORE_W(2)) bus_s ();

    assign bus_s.start         = bus.start;
    assign bus_s.lights        = bus.lights;
    assign bus_s.light_pos     = bus.light_pos;
    assign bus_s.light_counter = bus.light_counter;

    hit_detector #(
        .ROUNDS (3), .SCORE_W (8), .DEBOUNCE_CYCLES (28'(DB))
    ) dut (
        .clk (clk), .reset (reset), .buttons (buttons), .bus (bus)
    );

    hit_detector #(
        .ROUNDS (30), .SCORE_W (2), .DEBOUNCE_CYCLES (28'(DB))
    ) dut_s (
        .clk (clk), .reset (reset), .buttons (buttons), .bus (bus_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sat_hits = 0;
    int main_misses = 0;

    always @(negedge clk) begin
        if (bus_s.hit_pulse) sat_hits++;
        if (bus.miss_pulse)  main_misses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one cycle before the pulse from this press is registered.
    task automatic press_btn(input logic [8:0] m);
        buttons = m;
        tick(HOLD);
        buttons = '0;
        tick(LAT - 1 - HOLD);
    endtask

    task automatic light_on(input int pos, input int cnt);
        bus.lights        = (pos <= 8) ? 9'(1 << pos) : 9'h001;
        bus.light_pos     = 4'(pos);
        bus.light_counter = 6'(cnt);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_score"},  32'(bus.score),      0);
        check({tag, "_misses"}, 32'(bus.misses),     0);
        check({tag, "_hitp"},   32'(bus.hit_pulse),  0);
        check({tag, "_missp"},  32'(bus.miss_pulse), 0);
        check({tag, "_over"},   32'(bus.game_over),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    int base;

    initial begin
        reset = 1'b1;
        buttons = '0;
        bus.start = 1'b0;
        bus.lights = '0;
        bus.light_pos = '0;
        bus.light_counter = '0;
        @(posedge clk); #1;
        tick(2);
        check_idle_outputs("rst");
        reset = 1'b0;
        tick(1);

        // correct hit, then a repeat press on the same flick
        bus.start = 1'b1;
        tick(1);
        light_on(4, 1);
        tick(2);
        check("armed", 32'(dut.state_q), 32'(S_ARMED));
        press_btn(9'h010);
        check("hit_early", 32'(bus.hit_pulse), 0);
        tick(1);
        check("hit_pulse", 32'(bus.hit_pulse), 1);
        check("hit_score", 32'(bus.score), 1);
        tick(1);
        check("hit_width", 32'(bus.hit_pulse), 0);
        press_btn(9'h010);
        tick(1);
        check("repress_score", 32'(bus.score), 1);
        check("repress_miss",  32'(bus.misses), 0);
        bus.lights = '0;
        tick(2);
        check("wait_after", 32'(dut.state_q), 32'(S_WAIT_LIGHT));

        // wrong button
        light_on(2, 2);
        tick(2);
        press_btn(9'h080);
        tick(1);
        check("wrong_pulse",  32'(bus.miss_pulse), 1);
        check("wrong_misses", 32'(bus.misses), 1);
        check("wrong_score",  32'(bus.score), 1);
        bus.lights = '0;
        tick(2);

        // correct and wrong together
        light_on(2, 2);
        tick(2);
        press_btn(9'h084);
        tick(1);
        check("simul_pulse",  32'(bus.hit_pulse), 1);
        check("simul_score",  32'(bus.score), 2);
        check("simul_misses", 32'(bus.misses), 1);
        bus.lights = '0;
        tick(2);

        // false whack with no light
        press_btn(9'h001);
        tick(1);
        check("false_pulse",  32'(bus.miss_pulse), 1);
        check("false_misses", 32'(bus.misses), 2);

        // press coincides with the light appearing: still a false whack
        press_btn(9'h008);
        light_on(3, 1);
        tick(1);
        check("race_misses", 32'(bus.misses), 3);
        check("race_score",  32'(bus.score), 2);
        check("race_armed",  32'(dut.state_q), 32'(S_ARMED));

        // light expires unhit
        bus.lights = '0;
        tick(1);
        check("timeout_pulse",  32'(bus.miss_pulse), 1);
        check("timeout_misses", 32'(bus.misses), 4);
        check("timeout_state",  32'(dut.state_q), 32'(S_WAIT_LIGHT));

        // out-of-range position: matching button still a miss
        light_on(9, 2);
        tick(2);
        press_btn(9'h001);
        tick(1);
        check("pos9_misses", 32'(bus.misses), 5);
        check("pos9_score",  32'(bus.score), 2);
        bus.lights = '0;
        tick(2);

        // last round times out -> game over
        light_on(8, 3);
        tick(3);
        bus.lights = '0;
        tick(1);
        check("over_misses", 32'(bus.misses), 6);
        check("over_flag",   32'(bus.game_over), 1);
        press_btn(9'h100);
        tick(1);
        check("frozen_misses", 32'(bus.misses), 6);
        check("frozen_score",  32'(bus.score), 2);
        bus.start = 1'b0;
        tick(1);
        check("idle_over",  32'(bus.game_over), 0);
        check("idle_state", 32'(dut.state_q), 32'(S_IDLE));
        check("idle_score", 32'(bus.score), 2);
        bus.start = 1'b1;
        tick(1);
        check("restart_score",  32'(bus.score), 0);
        check("restart_misses", 32'(bus.misses), 0);

        // five hits: 2-bit instance saturates at 3 but pulses every time
        base = sat_hits;
        for (int i = 0; i < 5; i++) begin
            light_on(i, 1);
            tick(2);
            press_btn(9'(1 << i));
            tick(1);
            bus.lights = '0;
            tick(2);
            if (i == 3) begin
                check("sat_score",  32'(bus_s.score), 3);
                check("sat_pulses", 32'(sat_hits - base), 4);
                check("main_four",  32'(bus.score), 4);
            end
        end
        check("main_five", 32'(bus.score), 5);

        // reset in the middle of an armed flick
        light_on(5, 1);
        tick(2);
        check("pre_rst_state", 32'(dut.state_q), 32'(S_ARMED));
        reset = 1'b1;
        tick(1);
        check_idle_outputs("midrst");
        check("midrst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;
        bus.lights = '0;
        tick(2);

`ifdef WAM_DEBOUNCE_EN
        base = main_misses;
        buttons = 9'h020;
        tick(2);
        buttons = '0;
        tick(12);
        check("glitch_misses", 32'(bus.misses), 0);
        buttons = 9'h020;
        tick(6);
        buttons = '0;
        tick(12);
        check("hold_misses", 32'(bus.misses), 1);
        check("hold_pulses", 32'(main_misses - base), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
